// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: opcode encodings, default data
// width and the arbiter state enum.
package alu_pkg;

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_MUL = 4'd2;
  localparam logic [3:0] OP_EQ  = 4'd3;
  localparam logic [3:0] OP_GT  = 4'd4;
  // Highest legal opcode; anything above is answered with an error response.
  localparam logic [3:0] OP_MAX = 4'd4;

  localparam int unsigned DEFAULT_DATA_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    EXECUTE,
    RESPOND
  } arb_state_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin priority picker: returns the first asserted
// valid bit at or above the pointer, wrapping, as one-hot and as an index.
module rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] grant_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned      pos;
  logic [IDX_W-1:0] pos_idx;

  // Scan NUM_REQ positions starting at the pointer; first hit wins.
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    pos     = 0;
    pos_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      pos     = (32'(ptr_i) + k) % NUM_REQ;
      pos_idx = IDX_W'(pos);
      if (!any_o && valid_i[pos_idx]) begin
        any_o            = 1'b1;
        grant_o[pos_idx] = 1'b1;
        idx_o            = pos_idx;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between NUM_REQ
// requesters, one operation in flight, registered result returned over a
// per-requester valid/ready response handshake.
// Optional statistics counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int unsigned ALU_LATENCY = 1
) (
  input  logic                        clock_in,
  input  logic                        reset_in,
`ifdef ALU_ARB_STATS_EN
  output logic [15:0]                 stat_ops_out,
  output logic [7:0]                  stat_errors_out,
`endif
  input  logic [NUM_REQ-1:0]          req_valid_in,
  output logic [NUM_REQ-1:0]          req_ready_out,
  input  logic [4*NUM_REQ-1:0]        req_opcode_in,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_input1_in,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_input2_in,
  output logic [NUM_REQ-1:0]          resp_valid_out,
  input  logic [NUM_REQ-1:0]          resp_ready_in,
  output logic [DATA_WIDTH-1:0]       resp_data_out,
  output logic                        resp_error_out,
  output logic                        alu_enable_out,
  output logic [3:0]                  alu_opcode_out,
  output logic [DATA_WIDTH-1:0]       alu_input1_out,
  output logic [DATA_WIDTH-1:0]       alu_input2_out,
  input  logic [DATA_WIDTH-1:0]       alu_result_in
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = 3;

  arb_state_t            state_q, state_d;
  logic [IdxW-1:0]       ptr_q, ptr_d;
  logic [IdxW-1:0]       gnt_idx_q, gnt_idx_d;
  logic [3:0]            opcode_q, opcode_d;
  logic [DATA_WIDTH-1:0] in1_q, in1_d;
  logic [DATA_WIDTH-1:0] in2_q, in2_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  err_q, err_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  resp_done;

  logic [NUM_REQ-1:0]    pick_onehot;
  logic [IdxW-1:0]       pick_idx;
  logic                  pick_any;
  logic [3:0]            sel_opcode;
  logic [DATA_WIDTH-1:0] sel_in1;
  logic [DATA_WIDTH-1:0] sel_in2;

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_rr_picker (
    .valid_i (req_valid_in),
    .ptr_i   (ptr_q),
    .grant_o (pick_onehot),
    .idx_o   (pick_idx),
    .any_o   (pick_any)
  );

  // Mux the winning requester's opcode and operands out of the flat buses.
  always_comb begin
    sel_opcode = '0;
    sel_in1    = '0;
    sel_in2    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IdxW'(i)) begin
        sel_opcode = req_opcode_in[4*i +: 4];
        sel_in1    = req_input1_in[DATA_WIDTH*i +: DATA_WIDTH];
        sel_in2    = req_input2_in[DATA_WIDTH*i +: DATA_WIDTH];
      end
    end
  end

  // Next-state and handshake outputs for the IDLE/EXECUTE/RESPOND sequence.
  always_comb begin
    state_d        = state_q;
    ptr_d          = ptr_q;
    gnt_idx_d      = gnt_idx_q;
    opcode_d       = opcode_q;
    in1_d          = in1_q;
    in2_d          = in2_q;
    data_d         = data_q;
    err_d          = err_q;
    cnt_d          = cnt_q;
    resp_done      = 1'b0;
    req_ready_out  = '0;
    resp_valid_out = '0;
    alu_enable_out = 1'b0;
    unique case (state_q)
      IDLE: begin
        // Ready is gated by reset so every output reads 0 while it is held.
        if (pick_any && !reset_in) begin
          req_ready_out = pick_onehot;
          gnt_idx_d     = pick_idx;
          if (sel_opcode > OP_MAX) begin
            // Illegal opcode: answer straight away, ALU latches untouched.
            data_d  = '0;
            err_d   = 1'b1;
            state_d = RESPOND;
          end else begin
            opcode_d = sel_opcode;
            in1_d    = sel_in1;
            in2_d    = sel_in2;
            cnt_d    = '0;
            state_d  = EXECUTE;
          end
        end
      end
      EXECUTE: begin
        alu_enable_out = 1'b1;
        if (cnt_q == CntW'(ALU_LATENCY - 1)) begin
          data_d  = alu_result_in;
          err_d   = 1'b0;
          state_d = RESPOND;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RESPOND: begin
        resp_valid_out = NUM_REQ'(1) << gnt_idx_q;
        if (resp_ready_in[gnt_idx_q]) begin
          resp_done = 1'b1;
          ptr_d     = (gnt_idx_q == IdxW'(NUM_REQ - 1)) ? '0 : gnt_idx_q + IdxW'(1);
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_idx_q <= '0;
      opcode_q  <= '0;
      in1_q     <= '0;
      in2_q     <= '0;
      data_q    <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_idx_q <= gnt_idx_d;
      opcode_q  <= opcode_d;
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      data_q    <= data_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  // ALU inputs come straight from the latches, so they hold outside EXECUTE.
  assign alu_opcode_out = opcode_q;
  assign alu_input1_out = in1_q;
  assign alu_input2_out = in2_q;
  assign resp_data_out  = data_q;
  assign resp_error_out = err_q;

`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops_q;
  logic [7:0]  stat_err_q;

  // Completed-response counter wraps; error counter saturates.
  always_ff @(posedge clock_in or posedge reset_in) begin
    if (reset_in) begin
      stat_ops_q <= '0;
      stat_err_q <= '0;
    end else if (resp_done) begin
      stat_ops_q <= stat_ops_q + 16'd1;
      if (err_q && (stat_err_q != 8'hFF)) begin
        stat_err_q <= stat_err_q + 8'd1;
      end
    end
  end

  assign stat_ops_out    = stat_ops_q;
  assign stat_errors_out = stat_err_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: stimulus pushes expected responses,
// a negedge monitor pops and compares on every response handshake.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_opcode;
  logic [15:0] req_in1;
  logic [15:0] req_in2;
  logic [3:0]  resp_valid;
  logic [3:0]  resp_ready;
  logic [3:0]  resp_data;
  logic        resp_error;
  logic        alu_enable;
  logic [3:0]  alu_opcode;
  logic [3:0]  alu_in1;
  logic [3:0]  alu_in2;
  logic [3:0]  alu_result;
`ifdef ALU_ARB_STATS_EN
  logic [15:0] stat_ops;
  logic [7:0]  stat_errors;
`endif

  alu_arbiter #(
    .NUM_REQ     (4),
    .DATA_WIDTH  (4),
    .ALU_LATENCY (1)
  ) dut (
    .clock_in       (clk),
    .reset_in       (rst),
`ifdef ALU_ARB_STATS_EN
    .stat_ops_out   (stat_ops),
    .stat_errors_out(stat_errors),
`endif
    .req_valid_in   (req_valid),
    .req_ready_out  (req_ready),
    .req_opcode_in  (req_opcode),
    .req_input1_in  (req_in1),
    .req_input2_in  (req_in2),
    .resp_valid_out (resp_valid),
    .resp_ready_in  (resp_ready),
    .resp_data_out  (resp_data),
    .resp_error_out (resp_error),
    .alu_enable_out (alu_enable),
    .alu_opcode_out (alu_opcode),
    .alu_input1_out (alu_in1),
    .alu_input2_out (alu_in2),
    .alu_result_in  (alu_result)
  );

  // Environment ALU: the arbiter's downstream combinational unit.
  function automatic logic [3:0] alu_f(input logic [3:0] op, input logic [3:0] a,
                                       input logic [3:0] b);
    logic [7:0] p;
    p = a * b;
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return p[3:0];
      4'd3:    return {3'b000, a == b};
      4'd4:    return {3'b000, $signed(a) > $signed(b)};
      default: return 4'h0;
    endcase
  endfunction

  assign alu_result = alu_f(alu_opcode, alu_in1, alu_in2);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] onehot;
    logic [3:0] data;
    logic       err;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   failures;
  logic en_seen;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [3:0] data, input logic err);
    exp_t e;
    e.onehot = 4'b0001 << idx;
    e.data   = data;
    e.err    = err;
    sb_q.push_back(e);
  endtask

  // Monitor: compare every completed response against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] hs;
    if (!rst) begin
      if (alu_enable) en_seen = 1'b1;
      hs = resp_valid & resp_ready;
      if (hs != 4'b0) begin
        if (sb_q.size() == 0) begin
          check("unexpected_resp", {28'h0, hs}, 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("resp_requester", {28'h0, hs}, {28'h0, e.onehot});
          check("resp_data", {28'h0, resp_data}, {28'h0, e.data});
          check("resp_error", {31'h0, resp_error}, {31'h0, e.err});
        end
      end
    end
  end

  task automatic set_req(input int idx, input logic [3:0] op, input logic [3:0] a,
                         input logic [3:0] b);
    req_valid[idx]      = 1'b1;
    req_opcode[4*idx+:4] = op;
    req_in1[4*idx+:4]    = a;
    req_in2[4*idx+:4]    = b;
  endtask

  // Called just after a posedge; returns just after the posedge ending the handshake.
  task automatic issue(input int idx, input logic [3:0] op, input logic [3:0] a,
                       input logic [3:0] b);
    bit done;
    done = 1'b0;
    set_req(idx, op, a, b);
    for (int c = 0; c < 50 && !done; c++) begin
      @(negedge clk);
      if (req_ready[idx]) done = 1'b1;
    end
    if (!done) check("handshake_timeout", 32'h0, 32'h1);
    @(posedge clk);
    #1;
    req_valid[idx] = 1'b0;
  endtask

  task automatic wait_drain();
    bit done;
    done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) done = 1'b1;
    end
    if (!done) check("drain_timeout", sb_q.size(), 32'h0);
  endtask

  task automatic run_op(input int idx, input logic [3:0] op, input logic [3:0] a,
                        input logic [3:0] b, input logic [3:0] exp);
    push(idx, exp, 1'b0);
    issue(idx, op, a, b);
    wait_drain();
  endtask

  initial begin
    int n;
    logic [3:0] ord [6];
    ord = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd0, 4'd1};
    checks     = 0;
    failures   = 0;
    en_seen    = 1'b0;
    rst        = 1'b1;
    req_valid  = 4'b1111;
    req_opcode = '0;
    req_in1    = '0;
    req_in2    = '0;
    resp_ready = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset state: all outputs 0 even with requests pending.
    check("rst_req_ready", {28'h0, req_ready}, 32'h0);
    check("rst_resp_valid", {28'h0, resp_valid}, 32'h0);
    check("rst_alu_enable", {31'h0, alu_enable}, 32'h0);
    check("rst_alu_opcode", {28'h0, alu_opcode}, 32'h0);
    check("rst_resp_data", {28'h0, resp_data}, 32'h0);
    check("rst_resp_error", {31'h0, resp_error}, 32'h0);
    req_valid = '0;
    rst       = 1'b0;
    @(posedge clk);
    #1;

    // Single add with latency probes.
    resp_ready = 4'b1111;
    push(0, 4'h5, 1'b0);
    set_req(0, 4'd0, 4'd3, 4'd2);
    @(negedge clk);
    check("t1_ready", {28'h0, req_ready}, 32'h1);
    check("t1_en_T", {31'h0, alu_enable}, 32'h0);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("t1_en_T1", {31'h0, alu_enable}, 32'h1);
    check("t1_alu_ops", {20'h0, alu_opcode, alu_in1, alu_in2}, 32'h032);
    check("t1_resp_T1", {28'h0, resp_valid}, 32'h0);
    @(negedge clk);
    check("t1_resp_T2", {28'h0, resp_valid}, 32'h1);
    wait_drain();

    // Arithmetic vectors on requester 1.
    run_op(1, 4'd0, 4'h7, 4'h1, 4'h8);
    run_op(1, 4'd2, 4'h3, 4'h3, 4'h9);
    run_op(1, 4'd4, 4'hF, 4'h1, 4'h0);
    run_op(1, 4'd1, 4'h8, 4'h1, 4'h7);
    run_op(1, 4'd3, 4'h5, 4'h5, 4'h1);
    run_op(1, 4'd4, 4'h1, 4'hF, 4'h1);

    // All four requesting continuously from reset: grants rotate 0,1,2,3,0,1.
    rst = 1'b1;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    for (int i = 0; i < 6; i++) push(int'(ord[i]), 4'(ord[i] + 4'd4), 1'b0);
    for (int i = 0; i < 4; i++) set_req(i, 4'd0, 4'(i), 4'd4);
    n = 0;
    for (int c = 0; c < 100 && n < 6; c++) begin
      @(negedge clk);
      if (req_ready != 4'b0) begin
        check("rr_grant", {28'h0, req_ready}, {28'h0, 4'b0001 << ord[n]});
        n++;
      end
    end
    if (n < 6) check("rr_grant_count", n, 32'd6);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();

    // Illegal opcode on requester 2: immediate error response, ALU idle.
    en_seen = 1'b0;
    push(2, 4'h0, 1'b1);
    set_req(2, 4'hA, 4'h3, 4'h3);
    @(negedge clk);
    check("ill_ready", {28'h0, req_ready}, 32'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    check("ill_resp_T1", {28'h0, resp_valid}, 32'h4);
    wait_drain();
    check("ill_no_enable", {31'h0, en_seen}, 32'h0);

    // Response back-pressure on requester 2 with requester 0 waiting.
    resp_ready = 4'b1011;
    push(2, 4'h5, 1'b0);
    push(0, 4'h3, 1'b0);
    set_req(2, 4'd0, 4'h2, 4'h3);
    @(negedge clk);
    check("bp_ready", {28'h0, req_ready}, 32'h4);
    @(posedge clk);
    #1;
    req_valid = '0;
    set_req(0, 4'd0, 4'h1, 4'h2);
    @(negedge clk);
    check("bp_exec_ready", {28'h0, req_ready}, 32'h0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_hold", {23'h0, resp_valid, resp_data, req_ready, resp_error}, {23'h0, 4'h4, 4'h5, 4'h0, 1'b0});
    end
    @(posedge clk);
    #1;
    resp_ready = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    check("bp_next_grant", {28'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();

`ifdef ALU_ARB_STATS_EN
    check("stat_ops", {16'h0, stat_ops}, 32'd16);
    check("stat_errors", {24'h0, stat_errors}, 32'd1);
`endif

    // Reset during EXECUTE: outputs clear at once, no response, pointer back to 0.
    set_req(1, 4'd2, 4'h3, 4'h3);
    @(negedge clk);
    check("rx_ready", {28'h0, req_ready}, 32'h2);
    @(posedge clk);
    #1;
    req_valid = '0;
    check("rx_in_exec", {31'h0, alu_enable}, 32'h1);
    rst = 1'b1;
    #1;
    check("rx_outputs", {15'h0, alu_enable, alu_opcode, alu_in1, alu_in2, resp_valid, resp_data},
          32'h0);
    check("rx_resp_error", {31'h0, resp_error}, 32'h0);
`ifdef ALU_ARB_STATS_EN
    check("rx_stats", {8'h0, stat_ops, stat_errors}, 32'h0);
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    push(0, 4'h4, 1'b0);
    set_req(0, 4'd0, 4'h2, 4'h2);
    set_req(1, 4'd0, 4'h1, 4'h1);
    @(negedge clk);
    check("rx_first_grant", {28'h0, req_ready}, 32'h1);
    @(posedge clk);
    #1;
    req_valid = '0;
    wait_drain();
    repeat (5) @(posedge clk);
    check("final_sb_empty", sb_q.size(), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational signed ALU (opcodes add/sub/mul/eq/gt) between NUM_REQ requesters.
- Round-robin arbitration, a valid/ready request handshake, one operation in flight at a time, and a registered result returned to the granted requester over a valid/ready response handshake.
- Sits between the instruction/control units and the ALU; it is the only driver of the ALU's opcode, operand and enable inputs.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_WIDTH, 4, operand/result width, two's complement.
- ALU_LATENCY, 1, cycles the ALU inputs are held before the result is captured (1..7).

Ports:
- clock_in  in  1  system clock, rising edge
- reset_in  in  1  asynchronous, active-high reset
- req_valid_in  in  NUM_REQ  per-requester request valid
- req_ready_out  out  NUM_REQ  per-requester accept; one-hot or zero
- req_opcode_in  in  4*NUM_REQ  flattened opcodes, requester i at [4i+3:4i]
- req_input1_in  in  DATA_WIDTH*NUM_REQ  flattened operand 1
- req_input2_in  in  DATA_WIDTH*NUM_REQ  flattened operand 2
- resp_valid_out  out  NUM_REQ  per-requester response valid; one-hot or zero
- resp_ready_in  in  NUM_REQ  per-requester response accept
- resp_data_out  out  DATA_WIDTH  result, shared by all requesters
- resp_error_out  out  1  set with the response when the opcode was illegal
- alu_enable_out  out  1  ALU enable
- alu_opcode_out  out  4  ALU opcode
- alu_input1_out  out  DATA_WIDTH  ALU operand 1
- alu_input2_out  out  DATA_WIDTH  ALU operand 2
- alu_result_in  in  DATA_WIDTH  ALU output

Behaviour:
- Reset (asynchronous, active-high; applies immediately, including mid-operation):
  - state=IDLE; rr pointer=0; latched opcode/operands=0.
  - All outputs 0.
  - Any in-flight operation is discarded and no response is issued.
- IDLE:
  - grant = first i with req_valid_in[i]=1, searching from the pointer upward and wrapping.
  - req_ready_out[grant]=1 combinationally; all other ready bits 0.
  - Handshake completes on that cycle. Latch opcode/operands and the grant index.
  - Opcode <=4: go to EXECUTE. Opcode >4: go to RESPOND with data=0, error=1, and the ALU is never enabled.
  - No valid request: stay in IDLE, all ready bits 0.
- EXECUTE:
  - alu_enable_out=1; ALU opcode/operand outputs driven from the latches.
  - Count ALU_LATENCY cycles, capture alu_result_in on the last one, then go to RESPOND.
  - req_ready_out is all 0.
  - Outside EXECUTE, alu_enable_out=0 and the ALU opcode/operand outputs hold their last values (0 after reset).
- RESPOND:
  - resp_valid_out[grant]=1; resp_data_out and resp_error_out are stable.
  - Hold until resp_ready_in[grant]=1. On that cycle: pointer=(grant+1) mod NUM_REQ, state=IDLE.
  - resp_ready_in on non-granted bits is ignored.
- Latency:
  - Handshake cycle T; resp_valid high at T+1+ALU_LATENCY.
  - Best-case throughput is one operation per ALU_LATENCY+2 cycles.
- Result is the ALU output verbatim, truncated to DATA_WIDTH:
  - 7+1 → 4'h8; 3*3 → 4'h9.
  - eq/gt yield 0 or 1; gt is a signed compare.
- Simultaneous requests: exactly one is granted. Losers keep valid asserted and are served in rotation, so no requester starves.
- A requester dropping valid before ready is legal; it is simply not granted.
- resp_data_out/resp_error_out hold their value after the response until the next capture.

Optional Feature:
- Macro ALU_ARB_STATS_EN.
- Defined:
  - Adds outputs stat_ops_out (16 bits) and stat_errors_out (8 bits).
  - stat_ops_out counts completed responses and wraps.
  - stat_errors_out counts illegal-opcode responses and saturates at 255.
  - Both counters clear on reset.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg holds:
  - opcode localparams OP_ADD=0, OP_SUB=1, OP_MUL=2, OP_EQ=3, OP_GT=4, OP_MAX=4;
  - DATA_WIDTH default;
  - state enum arb_state_t {IDLE, EXECUTE, RESPOND}.
- Sub-module rr_picker: combinational round-robin priority picker (valid vector + pointer → one-hot grant + index), reused by future shared-resource blocks.

Test Plan:
- Req0 add 3+2 alone, resp_ready held high → ready0 at T, alu_enable high at T+1, resp_valid0 with data 4'h5, error 0 at T+2.
- Req1 add 7+1, then mul 3*3, then gt -1 vs 1 → data 4'h8, 4'h9, 4'h0; sub -8-1 → 4'h7.
- All 4 valid continuously after reset → grant order 0,1,2,3,0,1; each requester gets exactly one grant per rotation.
- Req2 opcode 4'hA → resp_valid2 one cycle after the handshake, data 0, error 1, alu_enable never asserted.
- Hold resp_ready2 low for 5 cycles → resp_valid2/data stable, no new ready issued; ready raised → IDLE next cycle.
- Assert reset during EXECUTE → all outputs 0 immediately, no response issued, the next request is granted starting from requester 0; with ALU_ARB_STATS_EN, the counters read 0.
